stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 14 +
 rtl/stopwatch_ctrl_key_edge.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 106 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state codes and
// the default terminal BCD value used by the controller and the counter chain.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  localparam logic [11:0] LIMIT_DEFAULT = 12'h321;

endpackage

// File: rtl/stopwatch_ctrl_key_edge.sv
// Key input conditioning: SYNC_STAGES-deep synchronizer followed by a
// history flop, producing a one-clk press pulse on each rising key edge.
module key_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld;
  logic                   hist;
  logic                   armed;

  // After reset the edge detector only arms once the synchronized key has
  // been genuinely observed low, so a key held through reset release is not
  // mistaken for a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      vld   <= '0;
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], key};
      vld   <= {vld[SYNC_STAGES-2:0], 1'b1};
      hist  <= sync[SYNC_STAGES-1];
      armed <= armed | (vld[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
    end
  end

  assign press = sync[SYNC_STAGES-1] & ~hist & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear keys drive a 4-state FSM
// that gates the external BCD counter, freezes the display and flags DONE.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter logic [11:0] LIMIT       = LIMIT_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_ss,
  input  logic       key_lc,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt0,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       lap_on,
  output logic       done,
  output logic [1:0] state
);

  sw_state_e   state_q;
  logic [11:0] lap_val;
  logic [11:0] cnt_live;
  logic        ss_press;
  logic        lc_press;
  logic        at_limit;

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_ss (
    .clk   (clk),
    .reset (reset),
    .key   (key_ss),
    .press (ss_press)
  );

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_lc (
    .clk   (clk),
    .reset (reset),
    .key   (key_lc),
    .press (lc_press)
  );

  assign cnt_live = {cnt2, cnt1, cnt0};
  assign at_limit = (cnt_live == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lap_on  <= 1'b0;
      cnt_clr <= 1'b0;
      lap_val <= '0;
    end else begin
      cnt_clr <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lc_press) begin
            cnt_clr <= 1'b1;
          end else if (ss_press) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // start/stop has priority; lap toggling and the terminal event
          // are independent of each other otherwise
          if (ss_press) begin
            state_q <= ST_PAUSE;
          end else begin
            if (lc_press) begin
              lap_on <= ~lap_on;
              if (!lap_on) lap_val <= cnt_live;
            end
            if (tick && at_limit) state_q <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (lc_press) begin
            cnt_clr <= 1'b1;
            lap_on  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (ss_press) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (lc_press) begin
            cnt_clr <= 1'b1;
            lap_on  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cnt_en                = tick & (state_q == ST_RUN) & ~at_limit;
  assign {disp2, disp1, disp0} = lap_on ? lap_val : cnt_live;
  assign done                  = (state_q == ST_DONE);
  assign state                 = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: table of key/tick steps against a BCD
// counter model, plus hand-written latency, tick/press overlap and reset checks.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       key_ss;
  logic       key_lc;
  logic [3:0] cnt2, cnt1, cnt0;
  logic       cnt_en, cnt_clr, lap_on, done;
  logic [3:0] disp2, disp1, disp0;
  logic [1:0] state;
  logic [11:0] disp_all;

  logic [11:0] model_cnt;
  logic        preset_en;
  logic [11:0] preset_val;
  int          en_count  = 0;
  int          clr_count = 0;
  int          tests     = 0;
  int          fails     = 0;

  stopwatch_ctrl #(.LIMIT(12'h321), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .key_ss  (key_ss),
    .key_lc  (key_lc),
    .cnt2    (cnt2),
    .cnt1    (cnt1),
    .cnt0    (cnt0),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .disp2   (disp2),
    .disp1   (disp1),
    .disp0   (disp0),
    .lap_on  (lap_on),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  assign {cnt2, cnt1, cnt0} = model_cnt;
  assign disp_all = {disp2, disp1, disp0};

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  // External BCD counter chain model
  always @(posedge clk or posedge reset) begin
    if (reset)          model_cnt <= '0;
    else if (preset_en) model_cnt <= preset_val;
    else if (cnt_clr)   model_cnt <= '0;
    else if (cnt_en)    model_cnt <= bcd_inc(model_cnt);
  end

  always @(posedge clk) begin
    if (cnt_en)  en_count  <= en_count + 1;
    if (cnt_clr) clr_count <= clr_count + 1;
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic press(input logic ss, input logic lc);
    @(negedge clk);
    key_ss = ss;
    key_lc = lc;
    repeat (3) @(negedge clk);
    key_ss = 1'b0;
    key_lc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_preset(input logic [11:0] v);
    @(negedge clk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  typedef struct {
    logic        ss;
    logic        lc;
    int unsigned ticks;
    logic        pre;
    logic [11:0] pre_val;
    logic [1:0]  exp_state;
    logic        exp_lap;
    logic [11:0] exp_disp;
    logic [11:0] exp_cnt;
    int          exp_en;
    int          exp_clr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ss, input logic lc, input int unsigned ticks,
                              input logic pre, input logic [11:0] pre_val,
                              input logic [1:0] st, input logic lap,
                              input logic [11:0] disp, input logic [11:0] cnt,
                              input int en, input int clr);
    vec_t v;
    v.ss = ss; v.lc = lc; v.ticks = ticks; v.pre = pre; v.pre_val = pre_val;
    v.exp_state = st; v.exp_lap = lap; v.exp_disp = disp; v.exp_cnt = cnt;
    v.exp_en = en; v.exp_clr = clr;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, c0;
    //             ss lc tk pre val     state    lap disp    cnt     en clr
    vecs[0]  = mk(1, 0, 0, 0, 12'h000, S_RUN,   0, 12'h000, 12'h000, 0, 0);
    vecs[1]  = mk(0, 0, 5, 0, 12'h000, S_RUN,   0, 12'h005, 12'h005, 5, 0);
    vecs[2]  = mk(0, 0, 0, 1, 12'h017, S_RUN,   0, 12'h017, 12'h017, 0, 0);
    vecs[3]  = mk(0, 1, 3, 0, 12'h000, S_RUN,   1, 12'h017, 12'h020, 3, 0);
    vecs[4]  = mk(0, 1, 0, 0, 12'h000, S_RUN,   0, 12'h020, 12'h020, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 12'h000, S_PAUSE, 0, 12'h020, 12'h020, 0, 0);
    vecs[6]  = mk(0, 0, 2, 0, 12'h000, S_PAUSE, 0, 12'h020, 12'h020, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 12'h000, S_RUN,   0, 12'h020, 12'h020, 0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 12'h320, S_RUN,   0, 12'h321, 12'h321, 1, 0);
    vecs[9]  = mk(0, 0, 1, 0, 12'h000, S_DONE,  0, 12'h321, 12'h321, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 12'h000, S_DONE,  0, 12'h321, 12'h321, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 12'h000, S_IDLE,  0, 12'h000, 12'h000, 0, 1);
    vecs[12] = mk(0, 1, 0, 0, 12'h000, S_IDLE,  0, 12'h000, 12'h000, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 12'h000, S_RUN,   0, 12'h000, 12'h000, 0, 0);
    vecs[14] = mk(0, 1, 2, 0, 12'h000, S_RUN,   1, 12'h000, 12'h002, 2, 0);
    vecs[15] = mk(1, 1, 0, 0, 12'h000, S_PAUSE, 1, 12'h000, 12'h002, 0, 0);
    vecs[16] = mk(1, 1, 0, 0, 12'h000, S_IDLE,  0, 12'h000, 12'h000, 0, 1);
    vecs[17] = mk(1, 0, 0, 0, 12'h000, S_RUN,   0, 12'h000, 12'h000, 0, 0);
    vecs[18] = mk(0, 1, 1, 1, 12'h321, S_DONE,  1, 12'h321, 12'h321, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, 12'h000, S_IDLE,  0, 12'h000, 12'h000, 0, 1);

    reset = 1'b1; tick = 1'b0; key_ss = 1'b0; key_lc = 1'b0;
    preset_en = 1'b0; preset_val = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 0, state, S_IDLE);
    check("rst_lap", 0, lap_on, 1'b0);
    check("rst_clr", 0, cnt_clr, 1'b0);
    check("rst_done", 0, done, 1'b0);
    check("rst_en", 0, cnt_en, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) do_preset(vecs[i].pre_val);
      e0 = en_count;
      c0 = clr_count;
      if (vecs[i].ss || vecs[i].lc) press(vecs[i].ss, vecs[i].lc);
      for (int unsigned t = 0; t < vecs[i].ticks; t++) do_tick();
      @(negedge clk);
      check("vec_state", i, state, vecs[i].exp_state);
      check("vec_done", i, done, (vecs[i].exp_state == S_DONE));
      check("vec_lap", i, lap_on, vecs[i].exp_lap);
      check("vec_disp", i, disp_all, vecs[i].exp_disp);
      check("vec_cnt", i, model_cnt, vecs[i].exp_cnt);
      check("vec_en_pulses", i, en_count - e0, vecs[i].exp_en);
      check("vec_clr_pulses", i, clr_count - c0, vecs[i].exp_clr);
    end

    // Key latency: edge sampled at k acts at k+2; holding gives one press
    @(negedge clk);
    key_ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_k1", 0, state, S_IDLE);
    @(negedge clk);
    check("lat_k2", 0, state, S_RUN);
    repeat (5) @(negedge clk);
    key_ss = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_one_press", 0, state, S_RUN);

    // Tick coinciding with a stop press still counts once
    @(negedge clk);
    key_ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    #1;
    check("tick_ss_en", 0, cnt_en, 1'b1);
    @(negedge clk);
    tick = 1'b0;
    check("tick_ss_state", 0, state, S_PAUSE);
    check("tick_ss_cnt", 0, model_cnt, 12'h001);
    key_ss = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-RUN with lap active and start key held
    press(1, 0);
    press(0, 1);
    do_tick();
    do_tick();
    @(negedge clk);
    check("pre_rst_lap", 0, lap_on, 1'b1);
    check("pre_rst_disp", 0, disp_all, 12'h001);
    key_ss = 1'b1;
    tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_state", 0, state, S_IDLE);
    check("arst_lap", 0, lap_on, 1'b0);
    check("arst_clr", 0, cnt_clr, 1'b0);
    check("arst_done", 0, done, 1'b0);
    check("arst_en", 0, cnt_en, 1'b0);
    check("arst_disp", 0, disp_all, 12'h000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick = 1'b0;
    repeat (6) @(negedge clk);
    check("held_no_press", 0, state, S_IDLE);
    key_ss = 1'b0;
    repeat (3) @(negedge clk);
    press(1, 0);
    check("repress_run", 0, state, S_RUN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
